// File: rtl/misc_pkg.sv
// Shared types for the misc request queue.
//   misc_op_e     : misc-manager op codes (MISC_IDLE is the "nothing this cycle" code)
//   misc_req_t    : captured request {op, port, data}; fields are MISC_MAX_W wide and
//                   users zero-extend their DATA_SIZE-wide values into them
//   misc_state_e  : request sequencer FSM states
//   misc_op_*()   : op classification helpers
package misc_pkg;

    // Widest DATA_SIZE a misc_req_t can carry.
    localparam int unsigned MISC_MAX_W = 64;

    typedef enum logic [3:0] {
        MISC_RAM_RD = 4'h0,
        MISC_RAM_WR = 4'h1,
        MISC_RECV   = 4'h2,
        MISC_SEND   = 4'h3,
        MISC_IDLE   = 4'hF
    } misc_op_e;

    typedef struct packed {
        logic [3:0]            op;
        logic [MISC_MAX_W-1:0] port;
        logic [MISC_MAX_W-1:0] data;
    } misc_req_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } misc_state_e;

    // Only 0000..0011 are defined; everything from 0100 up is rejected.
    function automatic logic misc_op_legal(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

    // Ops that address an I/O port rather than the RAM.
    function automatic logic misc_op_is_port(input logic [3:0] op);
        return (op == MISC_RECV) || (op == MISC_SEND);
    endfunction

    // Ops that carry a payload out and may be posted.
    function automatic logic misc_op_is_write(input logic [3:0] op);
        return (op == MISC_RAM_WR) || (op == MISC_SEND);
    endfunction

endpackage

// File: rtl/misc_req_fifo.sv
// Request FIFO for misc_req_queue: DEPTH entries of WIDTH bits, wrapping pointers.
//   clk, rstn      : clock, asynchronous active-low reset (empties the FIFO)
//   push_i/wdata_i : write an entry (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   rdata_o        : head entry, valid while !empty_o
//   count_o        : number of stored entries (0..DEPTH)
//   empty_o        : no entries stored
module misc_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/misc_req_queue.sv
// Misc request queue: buffers core requests in a FIFO and sequences them one at a time
// to the misc manager (IDLE -> ISSUE -> WAIT -> RESP), returning one response per
// request in acceptance order. Illegal ops (>= 0100) are answered with rsp_err_o=1,
// rsp_data_o=0 and never reach the misc manager.
//
// Build option: MISC_REQ_QUEUE_WRITE_ACK_EN
//   defined   -> RAM writes and port sends are acknowledged with a response
//   undefined -> RAM writes and port sends are posted (no response)
//
// Ports:
//   clk, rstn                       : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o         : request handshake
//   req_op_i, req_port_i, req_data_i: request op, RAM address / port number, payload
//   rsp_valid_o/rsp_ready_i         : response handshake
//   rsp_data_o, rsp_err_o           : response result and illegal-op flag
//   mm_cs_o, mm_op_o, mm_port_o,
//   mm_data_o                       : misc-manager command (MISC_IDLE outside ISSUE)
//   mm_result_i                     : misc-manager result, valid the cycle after ISSUE
//   issued_count_o                  : wrapping count of ops issued to the misc manager
module misc_req_queue
    import misc_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3:0]           req_op_i,
    input  logic [DATA_SIZE-1:0] req_port_i,
    input  logic [DATA_SIZE-1:0] req_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_SIZE-1:0] rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 mm_cs_o,
    output logic [3:0]           mm_op_o,
    output logic [DATA_SIZE-1:0] mm_port_o,
    output logic [DATA_SIZE-1:0] mm_data_o,
    input  logic [DATA_SIZE-1:0] mm_result_i,
    output logic [15:0]          issued_count_o
);

`ifdef MISC_REQ_QUEUE_WRITE_ACK_EN
    localparam bit WriteAck = 1'b1;
`else
    localparam bit WriteAck = 1'b0;
`endif

    localparam int unsigned EntryW = 4 + 2 * DATA_SIZE;
    localparam int unsigned CntW   = $clog2(DEPTH + 1);

    // FIFO interface
    logic              fifo_push;
    logic              fifo_pop;
    logic [EntryW-1:0] fifo_wdata;
    logic [EntryW-1:0] fifo_rdata;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_empty;

    logic [3:0]           head_op;
    logic [DATA_SIZE-1:0] head_port;
    logic [DATA_SIZE-1:0] head_data;

    // Sequencer state
    misc_state_e          state_q, state_d;
    misc_req_t            cur_q, cur_d;
    logic [DATA_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [15:0]          issued_q, issued_d;

    // No bypass: a full FIFO refuses a push even when the head is popped this cycle.
    assign req_ready_o = (fifo_count != CntW'(DEPTH));
    assign fifo_push   = req_valid_i && req_ready_o;
    assign fifo_wdata  = {req_op_i, req_port_i, req_data_i};

    assign head_op   = fifo_rdata[EntryW-1 -: 4];
    assign head_port = fifo_rdata[2*DATA_SIZE-1 -: DATA_SIZE];
    assign head_data = fifo_rdata[DATA_SIZE-1:0];

    misc_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        issued_d   = issued_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (misc_op_legal(head_op)) begin
                        cur_d.op   = head_op;
                        cur_d.port = MISC_MAX_W'(head_port);
                        cur_d.data = MISC_MAX_W'(head_data);
                        state_d    = StIssue;
                    end else begin
                        // Illegal op: answer directly, the misc manager never sees it.
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = StResp;
                    end
                end
            end
            StIssue: begin
                issued_d = issued_q + 16'd1;
                state_d  = StWait;
            end
            StWait: begin
                rsp_data_d = mm_result_i;
                rsp_err_d  = 1'b0;
                if (!WriteAck && misc_op_is_write(cur_q.op)) begin
                    state_d = StIdle;
                end else begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            issued_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            issued_q   <= issued_d;
        end
    end

    // The command is presented only during ISSUE so a RAM write is never repeated.
    always_comb begin
        mm_op_o   = MISC_IDLE;
        mm_cs_o   = 1'b0;
        mm_port_o = '0;
        mm_data_o = '0;
        if (state_q == StIssue) begin
            mm_op_o   = cur_q.op;
            mm_cs_o   = misc_op_is_port(cur_q.op);
            mm_port_o = cur_q.port[DATA_SIZE-1:0];
            mm_data_o = cur_q.data[DATA_SIZE-1:0];
        end
    end

    assign rsp_valid_o    = (state_q == StResp);
    assign rsp_data_o     = rsp_data_q;
    assign rsp_err_o      = rsp_err_q;
    assign issued_count_o = issued_q;

    // Upper struct bits are always zero-extended; they carry no information.
    if (DATA_SIZE < MISC_MAX_W) begin : g_unused_hi
        logic unused_cur_hi;
        assign unused_cur_hi = ^{cur_q.port[MISC_MAX_W-1:DATA_SIZE],
                                 cur_q.data[MISC_MAX_W-1:DATA_SIZE]};
    end

endmodule

// File: tb/tb_misc_req_queue.sv
// Directed bench for misc_req_queue with a small misc-manager model (16-word RAM,
// recv returns recv_val, send returns 16'h5A5A).
module tb_misc_req_queue;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
`ifdef MISC_REQ_QUEUE_WRITE_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    logic          clk;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [DW-1:0] req_port;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          mm_cs;
    logic [3:0]    mm_op;
    logic [DW-1:0] mm_port;
    logic [DW-1:0] mm_data;
    logic [DW-1:0] mm_result;
    logic [15:0]   issued_count;

    int tests_run    = 0;
    int tests_failed = 0;

    misc_req_queue #(
        .DATA_SIZE (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_port_i     (req_port),
        .req_data_i     (req_data),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .rsp_err_o      (rsp_err),
        .mm_cs_o        (mm_cs),
        .mm_op_o        (mm_op),
        .mm_port_o      (mm_port),
        .mm_data_o      (mm_data),
        .mm_result_i    (mm_result),
        .issued_count_o (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Misc-manager model
    logic          ram_init;
    logic [DW-1:0] ram [16];
    logic [DW-1:0] recv_val;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 16'h1000 + 16'(i);
            mm_result <= '0;
        end else begin
            case (mm_op)
                4'h0: mm_result <= ram[mm_port[3:0]];
                4'h1: begin
                    ram[mm_port[3:0]] <= mm_data;
                    mm_result         <= mm_data;
                end
                4'h2: mm_result <= recv_val;
                4'h3: mm_result <= 16'h5A5A;
                default: ;
            endcase
        end
    end

    // Monitor: response log and misc-manager activity counters
    logic [DW-1:0] rsp_log_data [$];
    logic          rsp_log_err  [$];
    int            wr_cycles   = 0;
    int            cs_cycles   = 0;
    int            busy_cycles = 0;
    logic [DW-1:0] last_port   = '0;
    logic [DW-1:0] last_data   = '0;

    always @(posedge clk) begin
        if (rstn) begin
            if (rsp_valid && rsp_ready) begin
                rsp_log_data.push_back(rsp_data);
                rsp_log_err.push_back(rsp_err);
            end
            if (mm_op == 4'h1) wr_cycles <= wr_cycles + 1;
            if (mm_cs) cs_cycles <= cs_cycles + 1;
            if (mm_op != 4'hF) begin
                busy_cycles <= busy_cycles + 1;
                last_port   <= mm_port;
                last_data   <= mm_data;
            end
        end
    end

    // Called at the "#1 after posedge" phase; returns at the same phase.
    task automatic push_req(input logic [3:0] op, input logic [DW-1:0] port,
                            input logic [DW-1:0] data);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL push_timeout: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_port  = port;
        req_data  = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        ram_init  = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_port  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        recv_val  = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++;
            $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++;
            $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        tests_run++; if (rsp_err !== 1'b0 || rsp_data !== 16'h0) begin tests_failed++;
            $display("FAIL reset_rsp: got err=%0b data=%h want 0/0000", rsp_err, rsp_data); end
        tests_run++; if (mm_op !== 4'hF || mm_cs !== 1'b0) begin tests_failed++;
            $display("FAIL reset_mm_op: got op=%h cs=%0b want F/0", mm_op, mm_cs); end
        tests_run++; if (mm_port !== 16'h0 || mm_data !== 16'h0) begin tests_failed++;
            $display("FAIL reset_mm_bus: got port=%h data=%h want 0", mm_port, mm_data); end
        tests_run++; if (issued_count !== 16'h0) begin tests_failed++;
            $display("FAIL reset_issued: got %h want 0000", issued_count); end
        rstn = 1'b1;
        @(posedge clk); #1;
        ram_init = 1'b0;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++;
            $display("FAIL first_cycle_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_reset_mid();
        int base_rsp;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_req(4'h0, 16'(i), 16'h0);
        // First read is waiting in RESP, the other three are queued.
        tests_run++; if (issued_count !== 16'd1 || rsp_valid !== 1'b1) begin tests_failed++;
            $display("FAIL mid_pre_reset: got issued=%0d rsp_valid=%0b want 1/1",
                     issued_count, rsp_valid); end
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++;
            $display("FAIL mid_pre_ready: got %0b want 1 (3 of 4 queued)", req_ready); end
        #2 rstn = 1'b0;
        #1;
        tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++;
            $display("FAIL mid_reset_hs: got ready=%0b rsp_valid=%0b want 1/0",
                     req_ready, rsp_valid); end
        tests_run++; if (mm_op !== 4'hF || issued_count !== 16'h0) begin tests_failed++;
            $display("FAIL mid_reset_state: got mm_op=%h issued=%0d want F/0",
                     mm_op, issued_count); end
        base_rsp = rsp_log_data.size();
        @(posedge clk); #1;
        rstn      = 1'b1;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        tests_run++; if (rsp_log_data.size() != base_rsp || issued_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_discard: got %0d responses issued=%0d want 0/0",
                     rsp_log_data.size() - base_rsp, issued_count); end
    endtask

    task automatic test_ram();
        int base_rsp, base_wr, n, exp_n;
        rsp_ready = 1'b1;
        base_rsp  = rsp_log_data.size();
        base_wr   = wr_cycles;
        exp_n     = 1 + ACK;
        push_req(4'h1, 16'd5, 16'hABCD);
        push_req(4'h0, 16'd5, 16'h0);
        n = 0;
        while (rsp_log_data.size() - base_rsp < exp_n && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        tests_run++; if (rsp_log_data.size() - base_rsp != exp_n) begin tests_failed++;
            $display("FAIL ram_rsp_count: got %0d want %0d",
                     rsp_log_data.size() - base_rsp, exp_n); end
        if (rsp_log_data.size() >= base_rsp + exp_n) begin
            tests_run++;
            if (rsp_log_data[base_rsp+exp_n-1] !== 16'hABCD ||
                rsp_log_err[base_rsp+exp_n-1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL ram_read_data: got %h err=%0b want ABCD/0",
                         rsp_log_data[base_rsp+exp_n-1], rsp_log_err[base_rsp+exp_n-1]);
            end
        end
        tests_run++; if (wr_cycles - base_wr != 1) begin tests_failed++;
            $display("FAIL ram_write_once: got %0d write cycles want 1", wr_cycles - base_wr); end
    endtask

    task automatic test_recv();
        int n, base_cs;
        recv_val  = 16'd1;
        rsp_ready = 1'b0;
        base_cs   = cs_cycles;
        push_req(4'h2, 16'd7, 16'h0);
        n = 0;
        while (mm_op !== 4'h2 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++; if (mm_op !== 4'h2 || mm_cs !== 1'b1 || mm_port !== 16'd7) begin
            tests_failed++;
            $display("FAIL recv_issue: got op=%h cs=%0b port=%0d want 2/1/7",
                     mm_op, mm_cs, mm_port); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++;
            $display("FAIL recv_issue_rsp: got rsp_valid=%0b want 0", rsp_valid); end
        @(posedge clk); #1;
        tests_run++; if (mm_cs !== 1'b0 || mm_op !== 4'hF || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL recv_wait: got cs=%0b op=%h rsp_valid=%0b want 0/F/0",
                     mm_cs, mm_op, rsp_valid); end
        @(posedge clk); #1;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd1 || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL recv_rsp: got valid=%0b data=%h err=%0b want 1/0001/0",
                     rsp_valid, rsp_data, rsp_err); end
        @(posedge clk); #1;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd1) begin tests_failed++;
            $display("FAIL recv_hold: got valid=%0b data=%h want 1/0001", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++;
            $display("FAIL recv_release: got rsp_valid=%0b want 0", rsp_valid); end
        tests_run++; if (cs_cycles - base_cs != 1) begin tests_failed++;
            $display("FAIL recv_cs_once: got %0d cs cycles want 1", cs_cycles - base_cs); end
    endtask

    task automatic test_back_to_back();
        int idx, n, base_rsp;
        logic ready_now;
        rsp_ready = 1'b0;
        base_rsp  = rsp_log_data.size();
        idx       = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (idx < DEPTH + 2);
            req_op    = 4'h0;
            req_port  = 16'(8 + idx);
            req_data  = 16'h0;
            ready_now = req_ready;
            @(posedge clk); #1;
            if (ready_now && req_valid) idx++;
        end
        req_valid = 1'b0;
        tests_run++; if (idx != DEPTH + 1) begin tests_failed++;
            $display("FAIL b2b_accepted: got %0d want %0d", idx, DEPTH + 1); end
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++;
            $display("FAIL b2b_full_ready: got %0b want 0", req_ready); end
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_log_data.size() - base_rsp < DEPTH + 1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++; if (rsp_log_data.size() - base_rsp != DEPTH + 1) begin tests_failed++;
            $display("FAIL b2b_rsp_count: got %0d want %0d",
                     rsp_log_data.size() - base_rsp, DEPTH + 1); end
        for (int i = 0; i <= DEPTH; i++) begin
            if (rsp_log_data.size() > base_rsp + i) begin
                tests_run++;
                if (rsp_log_data[base_rsp+i] !== 16'h1008 + 16'(i)) begin
                    tests_failed++;
                    $display("FAIL b2b_order[%0d]: got %h want %h", i,
                             rsp_log_data[base_rsp+i], 16'h1008 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_illegal();
        int n, base_busy;
        logic [15:0] base_issued;
        rsp_ready   = 1'b0;
        base_issued = issued_count;
        base_busy   = busy_cycles;
        push_req(4'h6, 16'd1, 16'd2);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0) begin
            tests_failed++;
            $display("FAIL illegal_rsp: got valid=%0b err=%0b data=%h want 1/1/0000",
                     rsp_valid, rsp_err, rsp_data); end
        tests_run++; if (issued_count !== base_issued || busy_cycles != base_busy) begin
            tests_failed++;
            $display("FAIL illegal_no_issue: got issued=%0d busy=%0d want %0d/%0d",
                     issued_count, busy_cycles, base_issued, base_busy); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++;
            $display("FAIL illegal_release: got rsp_valid=%0b want 0", rsp_valid); end
    endtask

    task automatic test_send();
        int base_rsp;
        logic [15:0] base_issued;
        rsp_ready   = 1'b1;
        base_rsp    = rsp_log_data.size();
        base_issued = issued_count;
        push_req(4'h3, 16'd2, 16'd9);
        repeat (15) @(posedge clk);
        #1;
        tests_run++; if (issued_count !== base_issued + 16'd1) begin tests_failed++;
            $display("FAIL send_issued: got %0d want %0d", issued_count, base_issued + 16'd1); end
        tests_run++; if (last_port !== 16'd2 || last_data !== 16'd9) begin tests_failed++;
            $display("FAIL send_bus: got port=%0d data=%0d want 2/9", last_port, last_data); end
        tests_run++; if (rsp_log_data.size() - base_rsp != ACK) begin tests_failed++;
            $display("FAIL send_rsp_count: got %0d want %0d",
                     rsp_log_data.size() - base_rsp, ACK); end
        if (rsp_log_data.size() > base_rsp) begin
            tests_run++;
            if (rsp_log_data[base_rsp] !== 16'h5A5A) begin tests_failed++;
                $display("FAIL send_ack_data: got %h want 5A5A", rsp_log_data[base_rsp]); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_ram();
        test_recv();
        test_back_to_back();
        test_illegal();
        test_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/misc_req_queue.md
MISC_REQ_QUEUE -- requirements
Module: misc_req_queue

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16, giving the port/data/result width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the request FIFO entries (power of two, >=2).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  core request present.
REQ-006 req_ready  output  1  FIFO can accept a request this cycle.
REQ-007 req_op  input  4  op code: 0000 RAM read, 0001 RAM write, 0010 port recv, 0011 port send.
REQ-008 req_port  input  DATA_SIZE  RAM address or I/O port number.
REQ-009 req_data  input  DATA_SIZE  write/send payload.
REQ-010 rsp_valid  output  1  response held for the core.
REQ-011 rsp_ready  input  1  core accepts the response.
REQ-012 rsp_data  output  DATA_SIZE  misc-manager result for the request.
REQ-013 rsp_err  output  1  request carried an illegal op (>=0100).
REQ-014 mm_cs, mm_op[4], mm_port[DATA_SIZE], mm_data[DATA_SIZE]  outputs  drive to the misc manager.
REQ-015 mm_result  input  DATA_SIZE  misc-manager result, updated after the posedge that samples mm_op.
REQ-016 issued_count  output  16  number of ops issued to the misc manager, wrapping.

Function
REQ-017 A request SHALL be pushed when req_valid && req_ready; req_ready SHALL equal (count != DEPTH), with no bypass when full, even if a pop occurs that cycle.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE: if the FIFO is non-empty, the FSM SHALL go to ISSUE if the head op is legal, else to RESP with rsp_err=1 and rsp_data=0; the head SHALL be popped on that transition.
REQ-020 ISSUE (one cycle): mm_op/mm_port/mm_data SHALL carry the captured request, and mm_cs SHALL be 1 only for ops 0010/0011; next state SHALL be WAIT.
REQ-021 In every state other than ISSUE, mm_op SHALL be 4'b1111 (idle), mm_cs 0, and mm_port/mm_data 0, so the misc manager never repeats a RAM write.
REQ-022 WAIT (one cycle): mm_result SHALL be captured into rsp_data at the end of WAIT; next state SHALL be RESP, or IDLE for a posted op (REQ-031).
REQ-023 RESP: rsp_valid SHALL be 1 and rsp_data/rsp_err held stable until rsp_ready; on rsp_valid && rsp_ready the FSM SHALL go to IDLE.
REQ-024 Latency from ISSUE entry to rsp_valid SHALL be exactly 2 cycles; throughput SHALL be at most one op per 3 cycles (4 with handshake).
REQ-025 issued_count SHALL increment once per ISSUE cycle and wrap from 0xFFFF to 0.
REQ-026 A push into an empty FIFO while in IDLE SHALL be visible at the head the next cycle (no same-cycle issue).
REQ-027 Requests SHALL be issued and answered strictly in acceptance order.

Reset
REQ-028 On rstn low, asynchronously: FIFO empty, FSM IDLE, rsp_valid=0, rsp_err=0, rsp_data=0, mm_op=1111, mm_cs=0, mm_port=0, mm_data=0, issued_count=0.
REQ-029 Reset mid-operation (any state) SHALL discard all queued and in-flight requests with no response.
REQ-030 req_ready SHALL be 1 in the first cycle after rstn deasserts.

Configuration
REQ-031 Macro MISC_REQ_QUEUE_WRITE_ACK_EN: defined -> ops 0001/0011 SHALL produce a response (rsp_data=mm_result); undefined -> those ops SHALL be posted (WAIT->IDLE, no rsp_valid). Error responses SHALL occur in both builds.

Structure
REQ-032 Package misc_pkg SHALL hold the op enum (MISC_RAM_RD, MISC_RAM_WR, MISC_RECV, MISC_SEND, MISC_IDLE=4'hF), the request struct {op, port, data}, and the FSM state enum.
REQ-033 The FIFO SHALL be the sub-module misc_req_fifo (DEPTH entries, pointer-wrap, count output); the FSM and counter SHALL live in misc_req_queue.

Verification
REQ-034 Reset with FIFO holding 3 requests -> req_ready=1, rsp_valid=0, mm_op=1111, issued_count=0; no responses appear.
REQ-035 RAM write port=5 data=0xABCD, then read port=5 (model mm_result from a RAM) -> read rsp_data=0xABCD; mm_op=0001 for exactly one cycle.
REQ-036 Recv op=0010 port=7 with mm_result=1 -> mm_cs=1 for one cycle only, rsp_valid 2 cycles after ISSUE, rsp_data=1.
REQ-037 Push DEPTH+1 requests back-to-back with rsp_ready=0 -> req_ready low after DEPTH accepted (plus one popped); order preserved once rsp_ready rises.
REQ-038 op=0110 -> no ISSUE, rsp_err=1, rsp_data=0, issued_count unchanged.
REQ-039 Send op=0011 port=2 data=9, both macro settings -> with macro one response; without, none, and issued_count increments by 1.
